dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dma_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Round-robin arbiter that hands one requester's DMA descriptor at a time to a single DMA engine.
// Each transfer is supervised by a WAIT-state timeout that aborts the transfer with an error.
module dma_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ-1:0]         req_dir,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       dma_cmd_valid,
    input  logic                       dma_cmd_ready,
    output logic [ADDR_W-1:0]          dma_addr,
    output logic [LEN_W-1:0]           dma_len,
    output logic                       dma_dir,
    input  logic                       dma_done,
    output logic                       dma_busy,
    output logic                       timeout_err
);

    // state | meaning
    // IDLE  | no transfer; arbitrate and capture a descriptor when any request is valid
    // ISSUE | command presented to the DMA, descriptor held until dma_cmd_ready
    // WAIT  | command accepted; wait for dma_done or the timeout terminal count

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                dir_q, dir_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                tout_q, tout_d;

    logic                found;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic [NUM_REQ-1:0]  grant;

    // Search starts one past the previous owner so a requester that stays valid
    // cannot win twice in a row while anyone else is waiting.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        dir_d   = dir_q;
        done_d  = '0;
        err_d   = '0;
        tout_d  = tout_q;
        grant   = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = NUM_REQ'(1) << win;
                    owner_d = win;
                    addr_d  = req_addr[win*ADDR_W +: ADDR_W];
                    len_d   = req_len[win*LEN_W +: LEN_W];
                    dir_d   = req_dir[win];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dma_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // dma_done takes priority over a coincident terminal count.
                if (dma_done) begin
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = IDLE;
                end else if (cnt_q == CNT_TERM) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    tout_d          = 1'b1;
                    last_d          = owner_q;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    // Grant is combinational so the requester sees it in the capture cycle; masked while in reset.
    assign req_grant     = grant & {NUM_REQ{rst_n}};
    assign req_done      = done_q;
    assign req_err       = err_q;
    assign dma_cmd_valid = (state_q == ISSUE);
    assign dma_busy      = (state_q != IDLE);
    assign dma_addr      = addr_q;
    assign dma_len       = len_q;
    assign dma_dir       = dir_q;
    assign timeout_err   = tout_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed testbench for dma_arbiter: arbitration order, handshake stall, timeout, reset abort.
module tb_dma_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*LW-1:0]   req_len;
    logic [NR-1:0]      req_dir;
    logic [NR-1:0]      req_grant;
    logic [NR-1:0]      req_done;
    logic [NR-1:0]      req_err;
    logic               dma_cmd_valid;
    logic               dma_cmd_ready;
    logic [AW-1:0]      dma_addr;
    logic [LW-1:0]      dma_len;
    logic               dma_dir;
    logic               dma_done;
    logic               dma_busy;
    logic               timeout_err;

    int tests  = 0;
    int failed = 0;

    dma_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_dir(req_dir),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
        .dma_addr(dma_addr), .dma_len(dma_len), .dma_dir(dma_dir),
        .dma_done(dma_done), .dma_busy(dma_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        req_valid = '0; dma_cmd_ready = 1'b0; dma_done = 1'b0; req_dir = 4'b1010;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = addr_of(i);
            req_len[i*LW +: LW]  = 16'(16 * (i + 1));
        end
        rst_n = 1'b0;
        #3;
        tests++;
        if ({req_grant, req_done, req_err} !== '0) begin
            failed++; $display("FAIL reset_req_outs: got %b/%b/%b expected 0", req_grant, req_done, req_err);
        end
        tests++;
        if ({dma_cmd_valid, dma_busy, timeout_err, dma_dir} !== 4'b0 || dma_addr !== '0 || dma_len !== '0) begin
            failed++; $display("FAIL reset_dma_outs: got v=%b b=%b t=%b a=%h l=%h expected all 0",
                               dma_cmd_valid, dma_busy, timeout_err, dma_addr, dma_len);
        end
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_rr_basic();
        dma_cmd_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        tests++;
        if (req_grant !== 4'b0010) begin
            failed++; $display("FAIL basic_grant1: got %b expected 0010", req_grant);
        end
        tick();
        req_valid = 4'b1000;
        #1;
        tests++;
        if (dma_cmd_valid !== 1'b1 || dma_addr !== addr_of(1) || dma_len !== 16'd32 || dma_dir !== 1'b1
            || req_grant !== 4'b0000) begin
            failed++; $display("FAIL basic_issue: got v=%b a=%h l=%0d d=%b g=%b expected 1/%h/32/1/0000",
                               dma_cmd_valid, dma_addr, dma_len, dma_dir, req_grant, addr_of(1));
        end
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        #1;
        tests++;
        if (req_done !== 4'b0010 || req_err !== 4'b0000 || req_grant !== 4'b1000 || dma_busy !== 1'b0) begin
            failed++; $display("FAIL basic_done1: got done=%b err=%b grant=%b busy=%b expected 0010/0000/1000/0",
                               req_done, req_err, req_grant, dma_busy);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        tests++;
        if (req_done !== 4'b1000 || req_err !== 4'b0000) begin
            failed++; $display("FAIL basic_done3: got done=%b err=%b expected 1000/0000", req_done, req_err);
        end
    endtask

    task automatic test_rr_all();
        logic [NR-1:0] exp_g;
        int order [5] = '{0, 1, 2, 3, 0};
        dma_cmd_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'(1) << order[k];
            tests++;
            if (req_grant !== exp_g) begin
                failed++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_grant, exp_g);
            end
            tick();
            tests++;
            if (dma_addr !== addr_of(order[k]) || dma_cmd_valid !== 1'b1) begin
                failed++; $display("FAIL rr_addr_%0d: got %h v=%b expected %h v=1", k, dma_addr, dma_cmd_valid,
                                   addr_of(order[k]));
            end
            tick();
            tick();
            tick();
            dma_done = 1'b1;
            tick();
            dma_done = 1'b0;
            if (k == 4) req_valid = 4'b0000;
            #1;
            tests++;
            if (req_done !== exp_g || req_err !== 4'b0000) begin
                failed++; $display("FAIL rr_done_%0d: got done=%b err=%b expected %b/0000", k, req_done, req_err, exp_g);
            end
        end
    endtask

    task automatic test_cmd_stall();
        dma_cmd_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_grant !== 4'b0100) begin
            failed++; $display("FAIL stall_grant: got %b expected 0100", req_grant);
        end
        tick();
        req_valid = 4'b0010;
        req_addr[2*AW +: AW] = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_valid = 4'b0000;
            #1;
            tests++;
            if (dma_cmd_valid !== 1'b1 || dma_addr !== addr_of(2) || dma_busy !== 1'b1) begin
                failed++; $display("FAIL stall_hold_%0d: got v=%b a=%h b=%b expected 1/%h/1", c, dma_cmd_valid,
                                   dma_addr, dma_busy, addr_of(2));
            end
            tick();
        end
        req_addr[2*AW +: AW] = addr_of(2);
        dma_cmd_ready = 1'b1;
        tick();
        tests++;
        if (dma_cmd_valid !== 1'b0 || dma_busy !== 1'b1) begin
            failed++; $display("FAIL stall_wait: got v=%b b=%b expected 0/1", dma_cmd_valid, dma_busy);
        end
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        #1;
        tests++;
        if (req_done !== 4'b0100 || req_grant !== 4'b0000) begin
            failed++; $display("FAIL stall_done: got done=%b grant=%b expected 0100/0000", req_done, req_grant);
        end
    endtask

    task automatic test_timeout();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        for (int c = 0; c < TO - 1; c++) tick();
        tests++;
        if (req_done !== 4'b0000 || dma_busy !== 1'b1 || timeout_err !== 1'b0) begin
            failed++; $display("FAIL tout_early: got done=%b busy=%b t=%b expected 0000/1/0", req_done, dma_busy,
                               timeout_err);
        end
        tick();
        tests++;
        if (req_done !== 4'b0001 || req_err !== 4'b0001 || timeout_err !== 1'b1 || dma_busy !== 1'b0) begin
            failed++; $display("FAIL tout_abort: got done=%b err=%b t=%b busy=%b expected 0001/0001/1/0",
                               req_done, req_err, timeout_err, dma_busy);
        end
        tick();
        tests++;
        if (req_done !== 4'b0000 || req_err !== 4'b0000 || timeout_err !== 1'b1) begin
            failed++; $display("FAIL tout_sticky: got done=%b err=%b t=%b expected 0000/0000/1", req_done, req_err,
                               timeout_err);
        end
    endtask

    task automatic test_done_at_terminal();
        apply_reset();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        for (int c = 0; c < TO - 1; c++) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        tests++;
        if (req_done !== 4'b0010 || req_err !== 4'b0000 || timeout_err !== 1'b0) begin
            failed++; $display("FAIL term_done: got done=%b err=%b t=%b expected 0010/0000/0", req_done, req_err,
                               timeout_err);
        end
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        tests++;
        if ({req_done, req_err, req_grant} !== '0 || dma_busy !== 1'b0 || dma_cmd_valid !== 1'b0
            || timeout_err !== 1'b0 || dma_addr !== addr_of(1)) begin
            failed++; $display("FAIL stray_done: got done=%b err=%b g=%b b=%b v=%b t=%b a=%h expected all idle",
                               req_done, req_err, req_grant, dma_busy, dma_cmd_valid, timeout_err, dma_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        rst_n = 1'b0;
        req_valid = 4'b1001;
        #1;
        tests++;
        if ({req_grant, req_done, req_err} !== '0 || {dma_cmd_valid, dma_busy, timeout_err} !== 3'b0
            || dma_addr !== '0) begin
            failed++; $display("FAIL rstw_immediate: got g=%b d=%b e=%b v=%b b=%b a=%h expected all 0",
                               req_grant, req_done, req_err, dma_cmd_valid, dma_busy, dma_addr);
        end
        tick();
        tick();
        tests++;
        if (req_done !== 4'b0000 || req_grant !== 4'b0000) begin
            failed++; $display("FAIL rstw_no_done: got done=%b grant=%b expected 0000/0000", req_done, req_grant);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_grant !== 4'b0001) begin
            failed++; $display("FAIL rstw_next_grant: got %b expected 0001", req_grant);
        end
        tick();
        req_valid = 4'b0000;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_rr_basic();
        test_rr_all();
        test_cmd_stall();
        test_timeout();
        test_done_at_terminal();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
